gcd_arbiter: RTL and testbench
==============================

// Module: gcd_arbiter
// PURPOSE
//  Shares one Euclidean GCD core among N_REQ requesters. Round-robin grant; requester operands are
//  latched and sequenced into the core (go/operands), completion is watched via the core's gld
//  strobe, and the result is returned with a per-requester done pulse. Zero operands bypass the
//  core (subtractive loop never terminates on 0). A watchdog aborts stuck operations.
// PARAMETERS
//  N_REQ    4   number of requesters (>=2)
//  W        4   operand/result width, matches core xin/yin/gcd
//  TIMEOUT  64  max cycles in WAIT before abort (>=2); counter width clog2(TIMEOUT)
// PORTS
//  clk       in   1        clock, rising edge
//  clr       in   1        asynchronous reset, active-low (0 = reset)
//  req       in   N_REQ    level request per requester
//  xin_bus   in   N_REQ*W  operand x, requester i at [i*W +: W]
//  yin_bus   in   N_REQ*W  operand y, same packing
//  gnt       out  N_REQ    one-cycle pulse: operands of requester i captured
//  done      out  N_REQ    one-cycle pulse: result for requester i valid on gcd_out/err
//  gcd_out   out  W        result, valid only in the done cycle, holds until next done
//  err       out  1        timeout flag, qualified by done
//  busy      out  1        1 in any state other than IDLE
//  core_go   out  1        start to core, held high ISSUE..WAIT
//  core_x    out  W        latched x to core, stable ISSUE..CAPTURE
//  core_y    out  W        latched y to core
//  core_gld  in   1        core result-register load strobe (completion)
//  core_gcd  in   W        core result, valid the cycle after core_gld
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE, gnt=0, done=0, gcd_out=0, err=0, busy=0, core_go=0,
//   core_x=core_y=0, rr pointer=0, watchdog=0. Any in-flight op is dropped; no done is issued.
//  FSM: IDLE -> ISSUE -> {WAIT -> CAPTURE | RESP} -> RESP -> IDLE.
//  IDLE: if |req, choose first asserted index at or above pointer (wrapping); latch idx, x, y.
//  ISSUE (1 cycle): gnt[idx]=1. If x==0 or y==0: result = x|y (0 if both zero), err=0, go RESP,
//   core_go stays 0. Else core_go=1, watchdog cleared, go WAIT.
//  WAIT: core_go=1; watchdog +1 per cycle. core_gld=1 -> CAPTURE. Else watchdog==TIMEOUT-1 ->
//   result=0, err=1, core_go=0, go RESP. core_gld takes priority over timeout in the same cycle.
//  CAPTURE (1 cycle): core_go=0, result<=core_gcd, go RESP.
//  RESP (1 cycle): done[idx]=1, gcd_out=result, err driven; pointer<=(idx+1) mod N_REQ; -> IDLE.
//  Latency: core path done = G+2 where G is the core_gld cycle; zero bypass done = T+2 where T
//   is the IDLE sample cycle. Throughput: one op in flight; IDLE always lasts >=1 cycle.
//  Handshake: requester holds req and operands until gnt; may change operands after gnt.
//   Dropping req before gnt withdraws the request. req still high after done = new request,
//   arbitrated behind others via pointer advance (no starvation: any req served within N_REQ ops).
//  gnt and done are one-hot or zero; never asserted together. core_gld outside WAIT is ignored.
// TESTING
//  1 req=0001, x0=12, y0=8, core model returns 4 -> gnt=0001 at T+1, core_go high, done=0001
//    at G+2, gcd_out=4, err=0.
//  2 req=1111 held from reset release -> gnt order 0,1,2,3,0; each done matches its operands.
//  3 req=0100, x2=0, y2=9 -> gnt at T+1, done=0100 at T+2, gcd_out=9, core_go never high;
//    x2=y2=0 -> gcd_out=0.
//  4 core model never pulses gld, TIMEOUT=64 -> done with err=1, gcd_out=0, core_go low,
//    next request served normally.
//  5 clr=0 during WAIT -> all outputs 0 same cycle, no done; after release req=0010 served
//    starting from pointer 0.
//  6 req1 raised then dropped while op for req0 in WAIT -> req1 never granted; gld coincident
//    with watchdog==TIMEOUT-1 -> err=0, core result returned.

Source files
------------

// File: rtl/gcd_arbiter_if.sv
// Bundle between requesters/GCD core (master side) and the gcd_arbiter (slave side).
// Requester operands are packed per index: requester i at [i*W +: W].
interface gcd_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 4
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] xin_bus;
    logic [N_REQ*W-1:0] yin_bus;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [W-1:0]       gcd_out;
    logic               err;
    logic               busy;
    logic               core_go;
    logic [W-1:0]       core_x;
    logic [W-1:0]       core_y;
    logic               core_gld;
    logic [W-1:0]       core_gcd;

    modport slave (
        input  req, xin_bus, yin_bus, core_gld, core_gcd,
        output gnt, done, gcd_out, err, busy, core_go, core_x, core_y
    );

    modport master (
        output req, xin_bus, yin_bus, core_gld, core_gcd,
        input  gnt, done, gcd_out, err, busy, core_go, core_x, core_y
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD core among N_REQ requesters, with zero-operand
// bypass and a WAIT watchdog. All outputs are registered.
module gcd_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         clr,
    gcd_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StResp} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_ptr;
    logic [W-1:0]     r_x;
    logic [W-1:0]     r_y;
    logic [CW-1:0]    r_wd;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic [W-1:0]     r_gcd_out;
    logic             r_err;
    logic             r_busy;
    logic             r_go;

    logic             w_found;
    logic [IW-1:0]    w_pick;
    logic [IW-1:0]    w_cand;
    logic [W-1:0]     w_x;
    logic [W-1:0]     w_y;
    logic [N_REQ-1:0] w_pick_oh;
    logic [N_REQ-1:0] w_idx_oh;

    // First asserted request at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_cand = IW'((32'(r_ptr) + 32'(k)) % N_REQ);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_x       = bus.xin_bus[32'(w_pick)*W +: W];
    assign w_y       = bus.yin_bus[32'(w_pick)*W +: W];
    assign w_pick_oh = N_REQ'(1) << w_pick;
    assign w_idx_oh  = N_REQ'(1) << r_idx;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_wd      <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_gcd_out <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_go      <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_idx   <= w_pick;
                        r_x     <= w_x;
                        r_y     <= w_y;
                        r_gnt   <= w_pick_oh;
                        r_busy  <= 1'b1;
                        // go is registered, so the bypass decision is made here
                        r_go    <= (w_x != '0) && (w_y != '0);
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    if ((r_x == '0) || (r_y == '0)) begin
                        r_gcd_out <= r_x | r_y;
                        r_err     <= 1'b0;
                        r_done    <= w_idx_oh;
                        r_state   <= StResp;
                    end else begin
                        r_wd    <= '0;
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (bus.core_gld) begin
                        r_go    <= 1'b0;
                        r_state <= StCapture;
                    end else if (r_wd == CW'(TIMEOUT - 1)) begin
                        r_gcd_out <= '0;
                        r_err     <= 1'b1;
                        r_go      <= 1'b0;
                        r_done    <= w_idx_oh;
                        r_state   <= StResp;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                StCapture: begin
                    r_gcd_out <= bus.core_gcd;
                    r_err     <= 1'b0;
                    r_done    <= w_idx_oh;
                    r_state   <= StResp;
                end
                StResp: begin
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.gcd_out = r_gcd_out;
    assign bus.err     = r_err;
    assign bus.busy    = r_busy;
    assign bus.core_go = r_go;
    assign bus.core_x  = r_x;
    assign bus.core_y  = r_y;
endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: vector table plus hand sequences for latency, timeout,
// reset abort, withdrawn requests and gld/timeout coincidence.
module tb_gcd_arbiter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   gld_at = 3;  // core model: gld this many cycles after go seen; 0 = never

    gcd_arbiter_if #(.N_REQ(N), .W(W)) bus_if ();

    gcd_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    function automatic int gcd_f(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural core: pulses gld once, result held on core_gcd.
    initial begin
        bit running;
        int cnt;
        running = 1'b0;
        cnt = 0;
        bus_if.core_gld = 1'b0;
        bus_if.core_gcd = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.core_gld = 1'b0;
            if (!running && bus_if.core_go) begin
                running = 1'b1;
                cnt = 0;
            end else if (running && bus_if.core_go) begin
                cnt++;
                if (cnt == gld_at) begin
                    bus_if.core_gld = 1'b1;
                    bus_if.core_gcd = W'(gcd_f(int'(bus_if.core_x), int'(bus_if.core_y)));
                end
            end else begin
                running = 1'b0;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic set_op(input int i, input int x, input int y);
        bus_if.xin_bus[i*W +: W] = W'(x);
        bus_if.yin_bus[i*W +: W] = W'(y);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.gnt == '0 && n < 300);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.done == '0 && n < 300);
    endtask

    typedef struct {
        int idx;
        int x;
        int y;
        int g;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        int bad;
        vecs[0] = '{0, 12, 8, 4};
        vecs[1] = '{1, 9, 6, 3};
        vecs[2] = '{2, 0, 9, 9};
        vecs[3] = '{3, 7, 0, 7};
        vecs[4] = '{2, 0, 0, 0};
        vecs[5] = '{1, 15, 5, 5};
        vecs[6] = '{3, 13, 7, 1};
        vecs[7] = '{0, 15, 15, 15};

        bus_if.req = '0;
        bus_if.xin_bus = '0;
        bus_if.yin_bus = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", int'(bus_if.gnt), 0);
        chk("rst_done", int'(bus_if.done), 0);
        chk("rst_busy", int'(bus_if.busy), 0);
        chk("rst_go", int'(bus_if.core_go), 0);

        // All four requesting from reset release: strict round-robin.
        gld_at = 2;
        set_op(0, 12, 8);
        set_op(1, 9, 6);
        set_op(2, 14, 10);
        set_op(3, 15, 5);
        bus_if.req = 4'b1111;
        clr = 1'b1;
        for (int g = 0; g < 5; g++) begin
            int exp_i;
            int exp_g[4];
            exp_g = '{4, 3, 2, 5};
            exp_i = g % 4;
            wait_gnt(n);
            chk("rr_gnt", int'(bus_if.gnt), 1 << exp_i);
            wait_done(n);
            chk("rr_done", int'(bus_if.done), 1 << exp_i);
            chk("rr_gcd", int'(bus_if.gcd_out), exp_g[exp_i]);
            if (g == 4) bus_if.req = '0;
        end
        @(negedge clk);

        // Core path latency: gnt at T+1, done at G+2.
        gld_at = 3;
        set_op(0, 12, 8);
        bus_if.req = 4'b0001;
        wait_gnt(n);
        chk("t1_gnt_lat", n, 1);
        chk("t1_gnt", int'(bus_if.gnt), 1);
        chk("t1_go", int'(bus_if.core_go), 1);
        chk("t1_busy", int'(bus_if.busy), 1);
        bus_if.req = '0;
        wait_done(n);
        chk("t1_done_lat", n, 5);
        chk("t1_done", int'(bus_if.done), 1);
        chk("t1_gcd", int'(bus_if.gcd_out), 4);
        chk("t1_err", int'(bus_if.err), 0);
        @(negedge clk);
        chk("t1_idle_busy", int'(bus_if.busy), 0);

        // Zero bypass.
        set_op(2, 0, 9);
        bus_if.req = 4'b0100;
        wait_gnt(n);
        chk("zb_gnt_lat", n, 1);
        chk("zb_go_issue", int'(bus_if.core_go), 0);
        bus_if.req = '0;
        wait_done(n);
        chk("zb_done_lat", n, 1);
        chk("zb_done", int'(bus_if.done), 4);
        chk("zb_gcd", int'(bus_if.gcd_out), 9);
        chk("zb_go_resp", int'(bus_if.core_go), 0);
        @(negedge clk);

        // Watchdog timeout.
        gld_at = 0;
        set_op(1, 9, 3);
        bus_if.req = 4'b0010;
        wait_gnt(n);
        bus_if.req = '0;
        wait_done(n);
        chk("to_done_lat", n, TO + 1);
        chk("to_done", int'(bus_if.done), 2);
        chk("to_err", int'(bus_if.err), 1);
        chk("to_gcd", int'(bus_if.gcd_out), 0);
        chk("to_go", int'(bus_if.core_go), 0);
        @(negedge clk);

        // Table vectors, normal service after the timeout.
        gld_at = 3;
        foreach (vecs[v]) begin
            set_op(vecs[v].idx, vecs[v].x, vecs[v].y);
            bus_if.req = N'(1) << vecs[v].idx;
            wait_gnt(n);
            chk($sformatf("vec%0d_gnt", v), int'(bus_if.gnt), 1 << vecs[v].idx);
            bus_if.req = '0;
            wait_done(n);
            chk($sformatf("vec%0d_done", v), int'(bus_if.done), 1 << vecs[v].idx);
            chk($sformatf("vec%0d_gcd", v), int'(bus_if.gcd_out), vecs[v].g);
            chk($sformatf("vec%0d_err", v), int'(bus_if.err), 0);
            @(negedge clk);
        end

        // Reset mid-WAIT: pointer is 2 (last served req1) before reset.
        set_op(1, 9, 6);
        bus_if.req = 4'b0010;
        wait_gnt(n);
        bus_if.req = '0;
        wait_done(n);
        @(negedge clk);
        gld_at = 0;
        set_op(2, 9, 6);
        bus_if.req = 4'b0100;
        wait_gnt(n);
        bus_if.req = '0;
        repeat (5) @(negedge clk);
        clr = 1'b0;
        #1;
        chk("ar_busy", int'(bus_if.busy), 0);
        chk("ar_go", int'(bus_if.core_go), 0);
        chk("ar_gcd", int'(bus_if.gcd_out), 0);
        chk("ar_cx", int'(bus_if.core_x), 0);
        chk("ar_cy", int'(bus_if.core_y), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_if.done != '0 || bus_if.gnt != '0) bad++;
        end
        chk("ar_quiet", bad, 0);
        gld_at = 2;
        set_op(1, 15, 10);
        set_op(2, 8, 12);
        bus_if.req = 4'b0110;
        clr = 1'b1;
        wait_gnt(n);
        chk("ar_ptr_gnt", int'(bus_if.gnt), 2);
        bus_if.req = 4'b0100;
        wait_done(n);
        chk("ar_gcd1", int'(bus_if.gcd_out), 5);
        wait_gnt(n);
        chk("ar_gnt2", int'(bus_if.gnt), 4);
        bus_if.req = '0;
        wait_done(n);
        chk("ar_gcd2", int'(bus_if.gcd_out), 4);
        @(negedge clk);

        // Withdrawn request while another op is in flight.
        gld_at = 5;
        set_op(0, 12, 8);
        bus_if.req = 4'b0001;
        wait_gnt(n);
        set_op(1, 6, 4);
        bus_if.req = 4'b0010;
        @(negedge clk);
        bus_if.req = '0;
        bad = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus_if.gnt != '0) bad++;
        end while (bus_if.done == '0 && n < 300);
        chk("wd_gcd", int'(bus_if.gcd_out), 4);
        repeat (4) begin
            @(negedge clk);
            if (bus_if.gnt != '0) bad++;
        end
        chk("wd_no_gnt", bad, 0);

        // gld coincident with watchdog==TIMEOUT-1: core result wins.
        gld_at = TO;
        set_op(3, 14, 10);
        bus_if.req = 4'b1000;
        wait_gnt(n);
        bus_if.req = '0;
        wait_done(n);
        chk("co_done_lat", n, TO + 2);
        chk("co_done", int'(bus_if.done), 8);
        chk("co_err", int'(bus_if.err), 0);
        chk("co_gcd", int'(bus_if.gcd_out), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
